// File: rtl/instr_feeder.sv
// Program sequencer feeding a processor's instruction input from a local program memory.
// Optional single-step mode (PAUSE state and `step` port) is enabled by defining FEEDER_STEP_EN.
module instr_feeder #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int MV_CYCLES  = 2,
    parameter int ALU_CYCLES = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [15:0]   load_data,
    input  logic          start,
    input  logic          abort,
`ifdef FEEDER_STEP_EN
    input  logic          step,
`endif
    input  logic [15:0]   outProcessador,
    output logic [15:0]   iin,
    output logic          proc_resetn,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic [15:0]   last_result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2
`ifdef FEEDER_STEP_EN
        ,
        S_PAUSE = 2'd3
`endif
    } state_t;

    localparam logic [2:0] OP_HALT = 3'b111;

    state_t        r_state;
    logic [15:0]   r_mem [DEPTH];
    logic [2:0]    r_cnt;
    logic [AW-1:0] r_pc;
    logic [15:0]   r_iin;
    logic [15:0]   r_last;
    logic          r_busy;
    logic          r_done;
    logic          r_procRstN;

    state_t        w_stateNext;
    logic [2:0]    w_cntNext;
    logic [AW-1:0] w_pcNext;
    logic [15:0]   w_iinNext;
    logic [15:0]   w_lastNext;
    logic          w_memWe;
    logic          w_busyNext;
    logic          w_doneNext;
    logic          w_procRstNNext;

    logic [AW-1:0] w_pcInc;
    logic [15:0]   w_nextWord;
    logic          w_nextHalt;
    logic          w_atEnd;
    logic          w_word0Halt;

    // Hold counter reload value: presentation length minus one.
    function automatic logic [2:0] holdLen(input logic [2:0] op);
        if (op == 3'b010 || op == 3'b011)
            holdLen = 3'(ALU_CYCLES - 1);
        else
            holdLen = 3'(MV_CYCLES - 1);
    endfunction

    assign w_pcInc     = r_pc + 1'b1;
    assign w_nextWord  = r_mem[w_pcInc];
    assign w_nextHalt  = (w_nextWord[15:13] == OP_HALT);
    assign w_atEnd     = (r_pc == AW'(DEPTH - 1));
    assign w_word0Halt = (r_mem[0][15:13] == OP_HALT);

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_pcNext    = r_pc;
        w_iinNext   = r_iin;
        w_lastNext  = r_last;
        w_memWe     = 1'b0;

        if (abort) begin
            w_stateNext = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (load_en) begin
                        w_memWe = 1'b1;
                    end else if (start) begin
                        if (w_word0Halt) begin
                            w_stateNext = S_DONE;
                        end else begin
                            w_pcNext    = '0;
                            w_iinNext   = r_mem[0];
                            w_cntNext   = holdLen(r_mem[0][15:13]);
                            w_stateNext = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cnt != 3'd0) begin
                        w_cntNext = r_cnt - 3'd1;
                    end else begin
                        w_lastNext = outProcessador;
                        if (w_atEnd || w_nextHalt) begin
                            w_stateNext = S_DONE;
                        end else begin
`ifdef FEEDER_STEP_EN
                            w_stateNext = S_PAUSE;
`else
                            w_pcNext    = w_pcInc;
                            w_iinNext   = w_nextWord;
                            w_cntNext   = holdLen(w_nextWord[15:13]);
                            w_stateNext = S_RUN;
`endif
                        end
                    end
                end
`ifdef FEEDER_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        w_pcNext    = w_pcInc;
                        w_iinNext   = w_nextWord;
                        w_cntNext   = holdLen(w_nextWord[15:13]);
                        w_stateNext = S_RUN;
                    end
                end
`endif
                default: begin
                    w_stateNext = S_IDLE;
                end
            endcase
        end

        // The processor never sees a word outside RUN/PAUSE.
        if (w_stateNext == S_IDLE || w_stateNext == S_DONE)
            w_iinNext = '0;

        w_busyNext     = (w_stateNext == S_RUN);
        w_doneNext     = (w_stateNext == S_DONE);
        w_procRstNNext = (w_stateNext == S_RUN) || (w_stateNext == S_DONE);
`ifdef FEEDER_STEP_EN
        if (w_stateNext == S_PAUSE)
            w_busyNext = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pc       <= '0;
            r_iin      <= '0;
            r_last     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_procRstN <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_pc       <= w_pcNext;
            r_iin      <= w_iinNext;
            r_last     <= w_lastNext;
            r_busy     <= w_busyNext;
            r_done     <= w_doneNext;
            r_procRstN <= w_procRstNNext;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_memWe) begin
            r_mem[load_addr] <= load_data;
        end
    end

    assign iin         = r_iin;
    assign proc_resetn = r_procRstN;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pc          = r_pc;
    assign last_result = r_last;

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: a program-level model predicts the per-cycle iin trace.
// Step-mode expectations are compiled in when FEEDER_STEP_EN is defined.
module tb_instr_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_data;
    logic          start;
    logic          abort;
`ifdef FEEDER_STEP_EN
    logic          step;
`endif
    logic [15:0]   outProcessador;
    logic [15:0]   iin;
    logic          proc_resetn;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;
    logic [15:0]   last_result;

    int checks   = 0;
    int failures = 0;

    // Reference state: program contents, last captured result, final pc.
    logic [15:0]   tbMem [DEPTH];
    logic [15:0]   tbLast;
    logic [AW-1:0] tbPc;

    instr_feeder #(
        .DEPTH(DEPTH), .AW(AW), .MV_CYCLES(2), .ALU_CYCLES(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .start(start),
        .abort(abort),
`ifdef FEEDER_STEP_EN
        .step(step),
`endif
        .outProcessador(outProcessador),
        .iin(iin),
        .proc_resetn(proc_resetn),
        .busy(busy),
        .done(done),
        .pc(pc),
        .last_result(last_result)
    );

    always #5 clk = ~clk;

    function automatic int presentLen(input logic [15:0] word);
        if (word[15:13] == 3'b010 || word[15:13] == 3'b011)
            return 4;
        return 2;
    endfunction

    task automatic loadWord(input int addr, input logic [15:0] data);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        @(posedge clk); #1;
        load_en   = 1'b0;
        tbMem[addr] = data;
    endtask

    // Runs whatever is in tbMem from address 0 and checks every cycle.
    // abortAt >= 0 asserts abort during that run cycle; loadBusy issues a load on cycle 1.
    task automatic runProgram(input int abortAt, input bit loadBusy);
        logic [15:0]   eWord[$];
        logic [AW-1:0] ePc[$];
        bit            eLast[$];
        logic [15:0]   drv;
        int            n;
        for (int i = 0; i < DEPTH; i++) begin
            if (tbMem[i][15:13] == 3'b111) break;
            n = presentLen(tbMem[i]);
            for (int k = 0; k < n; k++) begin
                eWord.push_back(tbMem[i]);
                ePc.push_back(AW'(i));
                eLast.push_back(k == n - 1);
            end
        end

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        for (int c = 0; c < eWord.size(); c++) begin
            checks += 5;
            if (iin !== eWord[c]) begin
                failures++; $display("[TB] FAIL run_iin cycle %0d: got %h want %h", c, iin, eWord[c]);
            end
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++; $display("[TB] FAIL run_flags cycle %0d: busy %b done %b want 1 0", c, busy, done);
            end
            if (proc_resetn !== 1'b1) begin
                failures++; $display("[TB] FAIL run_procrst cycle %0d: got %b want 1", c, proc_resetn);
            end
            if (pc !== ePc[c]) begin
                failures++; $display("[TB] FAIL run_pc cycle %0d: got %0d want %0d", c, pc, ePc[c]);
            end
            if (last_result !== tbLast) begin
                failures++; $display("[TB] FAIL run_last cycle %0d: got %h want %h", c, last_result, tbLast);
            end

            drv = 16'($urandom);
            outProcessador = drv;
            if (loadBusy && c == 1) begin
                load_en   = 1'b1;
                load_addr = '0;
                load_data = ~tbMem[0];
            end
            if (c == abortAt) abort = 1'b1;
            @(posedge clk); #1;
            load_en = 1'b0;

            if (abort) begin
                abort = 1'b0;
                checks += 4;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    failures++; $display("[TB] FAIL abort_flags: busy %b done %b want 0 0", busy, done);
                end
                if (iin !== 16'h0 || proc_resetn !== 1'b0) begin
                    failures++; $display("[TB] FAIL abort_outputs: iin %h procrst %b want 0000 0", iin, proc_resetn);
                end
                if (pc !== ePc[c]) begin
                    failures++; $display("[TB] FAIL abort_pc: got %0d want %0d", pc, ePc[c]);
                end
                if (last_result !== tbLast) begin
                    failures++; $display("[TB] FAIL abort_last: got %h want %h", last_result, tbLast);
                end
                tbPc = ePc[c];
                return;
            end

            if (eLast[c]) tbLast = drv;
`ifdef FEEDER_STEP_EN
            if (eLast[c] && c + 1 < eWord.size()) begin
                checks += 3;
                if (iin !== eWord[c] || pc !== ePc[c]) begin
                    failures++; $display("[TB] FAIL pause_hold: iin %h pc %0d want %h %0d", iin, pc, eWord[c], ePc[c]);
                end
                if (proc_resetn !== 1'b0 || busy !== 1'b1) begin
                    failures++; $display("[TB] FAIL pause_flags: procrst %b busy %b want 0 1", proc_resetn, busy);
                end
                if (last_result !== tbLast) begin
                    failures++; $display("[TB] FAIL pause_last: got %h want %h", last_result, tbLast);
                end
                step = 1'b1;
                @(posedge clk); #1;
                step = 1'b0;
            end
`endif
        end

        if (eWord.size() > 0) tbPc = ePc[eWord.size() - 1];
        checks += 4;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL end_flags: done %b busy %b want 1 0", done, busy);
        end
        if (iin !== 16'h0 || proc_resetn !== 1'b1) begin
            failures++; $display("[TB] FAIL end_outputs: iin %h procrst %b want 0000 1", iin, proc_resetn);
        end
        if (pc !== tbPc) begin
            failures++; $display("[TB] FAIL end_pc: got %0d want %0d", pc, tbPc);
        end
        if (last_result !== tbLast) begin
            failures++; $display("[TB] FAIL end_last: got %h want %h", last_result, tbLast);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; abort = 1'b0; outProcessador = '0;
`ifdef FEEDER_STEP_EN
        step = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) tbMem[i] = '0;
        tbLast = '0; tbPc = '0;
        #3;
        checks++;
        if ({iin, proc_resetn, busy, done, pc, last_result} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_values: iin %h procrst %b busy %b done %b pc %0d last %h want all 0",
                     iin, proc_resetn, busy, done, pc, last_result);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        loadWord(0, 16'h2400);
        loadWord(1, 16'h4200);
        loadWord(2, 16'hE000);
        runProgram(-1, 1'b0);
    endtask

    task automatic test_halt_first();
        loadWord(0, 16'hE000);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || iin !== 16'h0) begin
            failures++; $display("[TB] FAIL halt_first: done %b busy %b iin %h want 1 0 0000", done, busy, iin);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || pc !== tbPc) begin
            failures++; $display("[TB] FAIL halt_first_hold: busy %b pc %0d want 0 %0d", busy, pc, tbPc);
        end
    endtask

    task automatic test_abort();
        loadWord(0, 16'h2400);
        runProgram(2, 1'b1);
        runProgram(-1, 1'b0);
    endtask

    task automatic test_load_start();
        load_en = 1'b1; start = 1'b1;
        load_addr = AW'(3); load_data = 16'h6A5A;
        @(posedge clk); #1;
        load_en = 1'b0; start = 1'b0;
        tbMem[3] = 16'h6A5A;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("[TB] FAIL load_start_busy: got %b want 0", busy);
        end
        runProgram(-1, 1'b0);
    endtask

    task automatic test_random();
        int haltAt;
        for (int r = 0; r < 4; r++) begin
            haltAt = $urandom_range(1, 16);
            for (int i = 0; i < DEPTH; i++) begin
                logic [15:0] w;
                w = 16'($urandom);
                w[15:13] = 3'($urandom_range(0, 6));
                if (i == haltAt) w[15:13] = 3'b111;
                loadWord(i, w);
            end
            runProgram(-1, 1'b0);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) loadWord(i, 16'h0000);
        runProgram(-1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        loadWord(0, 16'h2400);
        loadWord(1, 16'h4200);
        loadWord(2, 16'hE000);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("[TB] FAIL pre_reset_busy: got %b want 1", busy);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({iin, proc_resetn, busy, done, pc, last_result} !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset: iin %h procrst %b busy %b done %b pc %0d last %h want all 0",
                     iin, proc_resetn, busy, done, pc, last_result);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < DEPTH; i++) tbMem[i] = '0;
        tbLast = '0; tbPc = '0;
        runProgram(-1, 1'b0);
    endtask

`ifdef FEEDER_STEP_EN
    task automatic test_step();
        loadWord(0, 16'h0123);
        loadWord(1, 16'h6001);
        loadWord(2, 16'hE000);
        runProgram(-1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_halt_first();
        test_abort();
        test_load_start();
        test_random();
        test_fill();
        test_reset_mid_run();
`ifdef FEEDER_STEP_EN
        test_step();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
